// File: rtl/uart_regf_init.sv
// uart_regf_init: valid/ready command to single-access regf mem bus initiator, one access in flight.
// Optional read polling is built only with UART_REGF_INIT_POLL_EN defined.
module uart_regf_init #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_SIZE  = 65536,
    parameter int RD_LAT     = 1,
    parameter int POLL_MAX   = 255
) (
    input  logic                  main_clk_i,
    input  logic                  main_rst_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_write_i,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [DATA_WIDTH-1:0] cmd_wdata_i,
    input  logic                  cmd_poll_i,
    input  logic [DATA_WIDTH-1:0] cmd_pval_i,
    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                  rsp_err_o,
    output logic                  rsp_tmo_o,
    output logic                  mem_ena_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic                  mem_wena_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    output logic                  mem_err_o
);
    typedef enum logic [2:0] {IDLE, ACC, WAIT, GAP, RSP} state_t;
    state_t state, nxt;
    logic wr, err, bad, cap, done, fail;
    assign bad = 33'(cmd_addr_i) >= 33'(ADDR_SIZE);
    assign cmd_ready_o = state == IDLE;
    assign rsp_valid_o = state == RSP;
    // cap marks the cycle in which the read data from the responder is valid
    assign cap = state == WAIT || (state == ACC && !wr && !err && RD_LAT == 0);
`ifdef UART_REGF_INIT_POLL_EN
    localparam int CW = $clog2(POLL_MAX + 1);
    logic poll;
    logic [DATA_WIDTH-1:0] pval;
    logic [CW-1:0] cnt;
    // the poll mask lives in mem_wdata_o, which is don't-care for reads
    assign fail = poll && (mem_rdata_i & mem_wdata_o) != pval;
    assign done = !fail || cnt == CW'(POLL_MAX);
    always_ff @(posedge main_clk_i) begin
        if (main_rst_i) begin
            poll <= 1'b0;
            pval <= '0;
            cnt <= '0;
            rsp_tmo_o <= 1'b0;
        end else begin
            if (state == IDLE && cmd_valid_i) begin
                poll <= cmd_poll_i && !cmd_write_i && !bad;
                pval <= cmd_pval_i;
                cnt <= CW'(1);
            end else if (cap && !done) cnt <= cnt + 1'b1;
            if (nxt == RSP && state != RSP) rsp_tmo_o <= cap && fail;
        end
    end
`else
    logic unused;
    assign unused = ^{cmd_poll_i, cmd_pval_i, POLL_MAX != 0};
    assign fail = 1'b0;
    assign done = 1'b1;
    assign rsp_tmo_o = 1'b0;
`endif
    always_comb begin
        nxt = state;
        case (state)
            IDLE: nxt = cmd_valid_i ? ACC : IDLE;
            ACC: nxt = (wr || err) ? RSP : (RD_LAT != 0) ? WAIT : done ? RSP : GAP;
            WAIT: nxt = done ? RSP : ACC;
            GAP: nxt = ACC;
            RSP: nxt = rsp_ready_i ? IDLE : RSP;
            default: nxt = IDLE;
        endcase
    end
    always_ff @(posedge main_clk_i) begin
        if (main_rst_i) begin
            state <= IDLE;
            wr <= 1'b0;
            err <= 1'b0;
            mem_ena_o <= 1'b0;
            mem_addr_o <= '0;
            mem_wena_o <= 1'b0;
            mem_wdata_o <= '0;
            mem_err_o <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_err_o <= 1'b0;
        end else begin
            state <= nxt;
            mem_ena_o <= nxt == ACC;
            if (state == IDLE && cmd_valid_i) begin
                wr <= cmd_write_i;
                err <= bad;
                mem_addr_o <= cmd_addr_i;
                mem_wdata_o <= cmd_wdata_i;
                mem_wena_o <= cmd_write_i && !bad;
                mem_err_o <= bad;
            end
            if (nxt == RSP && state != RSP) begin
                rsp_err_o <= err;
                rsp_rdata_o <= cap ? mem_rdata_i : '0;
            end
        end
    end
endmodule
